mem_access_ctrl: RTL and testbench
==================================

// Module: mem_access_ctrl
// PURPOSE
//  Initiator side of the data-memory interface. Accepts one load/store request at a time from the
//  datapath over a valid/ready handshake and drives mem_read/mem_write/address/write_data to data memory.
//  Captures read_data and returns it, with an error flag, over a valid/ready response channel.
//  Range-checks addresses against the memory depth and blocks out-of-range accesses.
// PARAMETERS
//  DATA_W     16  data word width
//  ADDR_W     16  address width
//  MEM_DEPTH  24  words implemented in data memory; legal addresses are 0..MEM_DEPTH-1
//  READ_WAIT  1   cycles mem_read is held before read_data is sampled (>=1)
// PORTS
//  clk         in   1       system clock, rising edge
//  reset       in   1       asynchronous, active-high reset
//  req_valid   in   1       request present
//  req_ready   out  1       request accepted when req_valid & req_ready at rising clk
//  req_write   in   1       1 = store, 0 = load
//  req_addr    in   ADDR_W  word address
//  req_wdata   in   DATA_W  store data
//  resp_valid  out  1       response present
//  resp_ready  in   1       response consumed when resp_valid & resp_ready at rising clk
//  resp_data   out  DATA_W  load data; 0 for stores and errors
//  resp_err    out  1       1 = address out of range; access not performed
//  mem_read    out  1       to data memory read enable
//  mem_write   out  1       to data memory write enable
//  address     out  ADDR_W  to data memory address
//  write_data  out  DATA_W  to data memory write data
//  read_data   in   DATA_W  from data memory; combinational, valid while mem_read=1
// BEHAVIOUR
//  Reset: state IDLE; wait counter 0; mem_read, mem_write, resp_valid and resp_err are 0;
//   address, write_data and resp_data are 0.
//   req_ready is 0 while reset is high and 1 in IDLE after release.
//  FSM states IDLE, WRITE, READ, RESP. req_ready = (state==IDLE) & ~reset. No other state accepts a request.
//  IDLE:  on accept, latch req_write, req_addr and req_wdata.
//   If req_addr >= MEM_DEPTH: go to RESP with resp_err=1 and resp_data=0. No memory strobe is issued.
//   Else go to WRITE on a store, or to READ with the counter cleared on a load.
//  WRITE: exactly one cycle. mem_write=1, address=latched addr, write_data=latched data.
//   The memory commits at the edge that ends this cycle. Then go to RESP with resp_err=0 and resp_data=0.
//  READ:  mem_read=1 and address=latched addr for READ_WAIT cycles. The counter increments each cycle.
//   On the final cycle, read_data is registered into resp_data, then go to RESP.
//  RESP:  resp_valid=1. resp_data and resp_err stay stable until the handshake.
//   On resp_ready, go to IDLE and clear resp_valid. The next request can be accepted 1 cycle later.
//  All memory-side outputs come from registered state (Moore); there is no combinational path from req_* to mem_*.
//   In IDLE and RESP: mem_read=mem_write=0, address=0, write_data=0.
//   mem_read and mem_write are never both 1.
//  Latency, accept edge to first resp_valid cycle: store 2 cycles; load 1+READ_WAIT cycles; range error 1 cycle.
//  Address compare is unsigned at full ADDR_W. Values >= MEM_DEPTH, including 0xFFFF, are errors.
//  Reset mid-transaction: mem_write and mem_read drop immediately (asynchronously). The access is aborted,
//   no response is produced, and the FSM is in IDLE after release.
//  req_* inputs may change freely after accept; only the latched copies are used.
// TESTING
//  Store 0x1234 to addr 5: mem_write=1 for exactly 1 cycle with address=5 and write_data=0x1234;
//   resp_valid 2 cycles after accept, resp_err=0.
//  Load addr 5 with memory word 5 = 0x1234 and READ_WAIT=1: mem_read=1 for 1 cycle;
//   resp_data=0x1234 and resp_valid 2 cycles after accept. Repeat with READ_WAIT=3: resp_valid 4 cycles after accept.
//  Load addr 24 and store addr 0xFFFF: no mem_read/mem_write pulse; resp_err=1, resp_data=0,
//   resp_valid 1 cycle after accept.
//  Hold resp_ready=0 for 3 cycles in RESP: resp_valid, resp_data and resp_err stay stable;
//   req_ready=0 and req_valid is ignored throughout.
//  Assert reset during the 2nd READ cycle (READ_WAIT=3): mem_read=0 within the same cycle; no resp_valid;
//   req_ready=1 on the first edge after release.
//  Back-to-back: store 0xBEEF to addr 23 then load addr 23, with resp_ready tied 1:
//   load returns 0xBEEF and no request is accepted while busy.

Source files
------------

// File: rtl/mem_access_ctrl_if.sv
// Request/response handshake plus data-memory strobes between datapath, controller and memory.
// master = datapath and memory side; slave = mem_access_ctrl.
interface mem_access_ctrl_if #(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 16
);
  logic              req_valid;
  logic              req_ready;
  logic              req_write;
  logic [ADDR_W-1:0] req_addr;
  logic [DATA_W-1:0] req_wdata;
  logic              resp_valid;
  logic              resp_ready;
  logic [DATA_W-1:0] resp_data;
  logic              resp_err;
  logic              mem_read;
  logic              mem_write;
  logic [ADDR_W-1:0] address;
  logic [DATA_W-1:0] write_data;
  logic [DATA_W-1:0] read_data;

  modport master (
    output req_valid, req_write, req_addr, req_wdata, resp_ready, read_data,
    input  req_ready, resp_valid, resp_data, resp_err, mem_read, mem_write, address, write_data
  );

  modport slave (
    input  req_valid, req_write, req_addr, req_wdata, resp_ready, read_data,
    output req_ready, resp_valid, resp_data, resp_err, mem_read, mem_write, address, write_data
  );
endinterface

// File: rtl/mem_access_ctrl.sv
// Single-outstanding load/store initiator to data memory with address range checking.
// Latency accept->resp_valid: store 2, load 1+READ_WAIT, out-of-range 1 cycle.
// Accepts only in IDLE; response is held stable in RESP until resp_ready.
module mem_access_ctrl #(
  parameter int DATA_W    = 16,
  parameter int ADDR_W    = 16,
  parameter int MEM_DEPTH = 24,
  parameter int READ_WAIT = 1
) (
  input logic              clk,
  input logic              reset,
  mem_access_ctrl_if.slave bus
);
  localparam int                CNT_W    = (READ_WAIT > 1) ? $clog2(READ_WAIT) : 1;
  localparam logic [CNT_W-1:0]  LAST_CNT = CNT_W'(READ_WAIT - 1);
  localparam logic [ADDR_W:0]   DEPTH_L  = (ADDR_W + 1)'(MEM_DEPTH);

  typedef enum logic [1:0] {IDLE, WRITE, READ, RESP} state_t;

  typedef struct packed {
    logic              write;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
  } req_t;

  state_t            state, state_nxt;
  req_t              req_q;
  logic [CNT_W-1:0]  cnt_q;
  logic [DATA_W-1:0] resp_data_q;
  logic              resp_err_q;
  logic              accept;
  logic              addr_oor;
  logic              last_rd;

  assign accept   = bus.req_valid && (state == IDLE) && !reset;
  // Widened by one bit so MEM_DEPTH == 2**ADDR_W still compares correctly.
  assign addr_oor = ({1'b0, bus.req_addr} >= DEPTH_L);
  assign last_rd  = (cnt_q == LAST_CNT);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt      = state;
    bus.req_ready  = 1'b0;
    bus.resp_valid = 1'b0;
    bus.mem_read   = 1'b0;
    bus.mem_write  = 1'b0;
    bus.address    = '0;
    bus.write_data = '0;
    case (state)
      IDLE: begin
        bus.req_ready = !reset;
        if (accept) begin
          if (addr_oor)           state_nxt = RESP;
          else if (bus.req_write) state_nxt = WRITE;
          else                    state_nxt = READ;
        end
      end
      WRITE: begin
        bus.mem_write  = req_q.write;
        bus.address    = req_q.addr;
        bus.write_data = req_q.wdata;
        state_nxt      = RESP;
      end
      READ: begin
        bus.mem_read = !req_q.write;
        bus.address  = req_q.addr;
        if (last_rd) state_nxt = RESP;
      end
      RESP: begin
        bus.resp_valid = 1'b1;
        if (bus.resp_ready) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      req_q       <= '0;
      cnt_q       <= '0;
      resp_data_q <= '0;
      resp_err_q  <= 1'b0;
    end else begin
      if (accept) begin
        req_q       <= '{write: bus.req_write, addr: bus.req_addr, wdata: bus.req_wdata};
        cnt_q       <= '0;
        resp_err_q  <= addr_oor;
        resp_data_q <= '0;
      end
      if (state == READ) begin
        cnt_q <= cnt_q + CNT_W'(1);
        if (last_rd) resp_data_q <= bus.read_data;
      end
    end
  end

  assign bus.resp_data = resp_data_q;
  assign bus.resp_err  = resp_err_q;
endmodule

// File: tb/tb_mem_access_ctrl.sv
// Directed bench: u_dut1 uses READ_WAIT=1, u_dut3 uses READ_WAIT=3; each has its own 24-word memory model.
module tb_mem_access_ctrl;
  logic clk;
  logic reset;
  int   checks;
  int   errors;
  int   wr_cnt1, rd_cnt1, rd_cnt3, acc_cnt1;
  bit   both_seen;

  logic [15:0] mem1 [0:23];
  logic [15:0] mem3 [0:23];

  mem_access_ctrl_if #(.DATA_W(16), .ADDR_W(16)) i1 ();
  mem_access_ctrl_if #(.DATA_W(16), .ADDR_W(16)) i3 ();

  mem_access_ctrl #(.DATA_W(16), .ADDR_W(16), .MEM_DEPTH(24), .READ_WAIT(1)) u_dut1 (
    .clk(clk), .reset(reset), .bus(i1.slave));
  mem_access_ctrl #(.DATA_W(16), .ADDR_W(16), .MEM_DEPTH(24), .READ_WAIT(3)) u_dut3 (
    .clk(clk), .reset(reset), .bus(i3.slave));

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  assign i1.read_data = (i1.mem_read && i1.address < 16'd24) ? mem1[i1.address[4:0]] : 16'hDEAD;
  assign i3.read_data = (i3.mem_read && i3.address < 16'd24) ? mem3[i3.address[4:0]] : 16'hDEAD;

  always @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < 24; i++) begin
        mem1[i] <= 16'h0000;
        mem3[i] <= 16'h0000;
      end
      mem3[5] <= 16'h1234;
    end else begin
      if (i1.mem_write && i1.address < 16'd24) mem1[i1.address[4:0]] <= i1.write_data;
      if (i3.mem_write && i3.address < 16'd24) mem3[i3.address[4:0]] <= i3.write_data;
    end
  end

  always @(posedge clk) begin
    if (i1.mem_write) wr_cnt1++;
    if (i1.mem_read) rd_cnt1++;
    if (i3.mem_read) rd_cnt3++;
    if (i1.req_valid && i1.req_ready) acc_cnt1++;
    if ((i1.mem_read && i1.mem_write) || (i3.mem_read && i3.mem_write)) both_seen = 1'b1;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    repeat (2) @(posedge clk);
    #1;
    checks++; if (i1.req_ready !== 1'b0) begin errors++; $display("FAIL rst_req_ready: got %b want 0", i1.req_ready); end
    checks++; if ({i1.mem_read, i1.mem_write, i1.resp_valid, i1.resp_err} !== 4'b0000) begin
      errors++; $display("FAIL rst_flags: got %b want 0000", {i1.mem_read, i1.mem_write, i1.resp_valid, i1.resp_err}); end
    checks++; if ({i1.address, i1.write_data, i1.resp_data} !== 48'h0) begin
      errors++; $display("FAIL rst_buses: got %h want 0", {i1.address, i1.write_data, i1.resp_data}); end
    checks++; if ({i3.req_ready, i3.mem_read, i3.resp_valid} !== 3'b000) begin
      errors++; $display("FAIL rst_dut3: got %b want 000", {i3.req_ready, i3.mem_read, i3.resp_valid}); end
    reset = 1'b0;
    tick();
    checks++; if ({i1.req_ready, i3.req_ready} !== 2'b11) begin
      errors++; $display("FAIL rst_release_ready: got %b want 11", {i1.req_ready, i3.req_ready}); end
  endtask

  task automatic test_store();
    int w0 = wr_cnt1;
    i1.req_valid = 1'b1; i1.req_write = 1'b1; i1.req_addr = 16'd5; i1.req_wdata = 16'h1234; i1.resp_ready = 1'b1;
    tick();
    i1.req_valid = 1'b0; i1.req_addr = 16'd9; i1.req_wdata = 16'hFFFF;
    checks++; if ({i1.mem_write, i1.mem_read, i1.resp_valid} !== 3'b100) begin
      errors++; $display("FAIL store_c1_strobes: got %b want 100", {i1.mem_write, i1.mem_read, i1.resp_valid}); end
    checks++; if ({i1.address, i1.write_data} !== {16'd5, 16'h1234}) begin
      errors++; $display("FAIL store_c1_addr_data: got %h want 00051234", {i1.address, i1.write_data}); end
    tick();
    checks++; if ({i1.resp_valid, i1.resp_err, i1.mem_write} !== 3'b100) begin
      errors++; $display("FAIL store_c2_resp: got %b want 100", {i1.resp_valid, i1.resp_err, i1.mem_write}); end
    checks++; if (i1.resp_data !== 16'h0000) begin errors++; $display("FAIL store_resp_data: got %h want 0000", i1.resp_data); end
    checks++; if (wr_cnt1 - w0 !== 1) begin errors++; $display("FAIL store_pulse_count: got %0d want 1", wr_cnt1 - w0); end
    checks++; if (mem1[5] !== 16'h1234) begin errors++; $display("FAIL store_mem5: got %h want 1234", mem1[5]); end
    tick();
    checks++; if ({i1.resp_valid, i1.req_ready} !== 2'b01) begin
      errors++; $display("FAIL store_done: got %b want 01", {i1.resp_valid, i1.req_ready}); end
  endtask

  task automatic test_load_rw1();
    int r0 = rd_cnt1;
    i1.req_valid = 1'b1; i1.req_write = 1'b0; i1.req_addr = 16'd5; i1.resp_ready = 1'b1;
    tick();
    i1.req_valid = 1'b0; i1.req_addr = 16'd0;
    checks++; if ({i1.mem_read, i1.resp_valid, i1.address} !== {2'b10, 16'd5}) begin
      errors++; $display("FAIL load1_c1: got %h want 2_0005", {i1.mem_read, i1.resp_valid, i1.address}); end
    tick();
    checks++; if ({i1.resp_valid, i1.resp_err, i1.mem_read} !== 3'b100) begin
      errors++; $display("FAIL load1_c2_resp: got %b want 100", {i1.resp_valid, i1.resp_err, i1.mem_read}); end
    checks++; if (i1.resp_data !== 16'h1234) begin errors++; $display("FAIL load1_data: got %h want 1234", i1.resp_data); end
    checks++; if (rd_cnt1 - r0 !== 1) begin errors++; $display("FAIL load1_pulse_count: got %0d want 1", rd_cnt1 - r0); end
    tick();
  endtask

  task automatic test_load_rw3();
    int r0 = rd_cnt3;
    i3.req_valid = 1'b1; i3.req_write = 1'b0; i3.req_addr = 16'd5; i3.resp_ready = 1'b1;
    tick();
    i3.req_valid = 1'b0;
    for (int c = 1; c <= 3; c++) begin
      checks++; if ({i3.mem_read, i3.resp_valid, i3.address} !== {2'b10, 16'd5}) begin
        errors++; $display("FAIL load3_c%0d: got %h want 2_0005", c, {i3.mem_read, i3.resp_valid, i3.address}); end
      tick();
    end
    checks++; if ({i3.resp_valid, i3.mem_read, i3.resp_data} !== {2'b10, 16'h1234}) begin
      errors++; $display("FAIL load3_c4_resp: got %h want 2_1234", {i3.resp_valid, i3.mem_read, i3.resp_data}); end
    checks++; if (rd_cnt3 - r0 !== 3) begin errors++; $display("FAIL load3_pulse_count: got %0d want 3", rd_cnt3 - r0); end
    tick();
  endtask

  task automatic test_range_err();
    int w0 = wr_cnt1;
    int r0 = rd_cnt1;
    i1.req_valid = 1'b1; i1.req_write = 1'b0; i1.req_addr = 16'd24; i1.resp_ready = 1'b1;
    tick();
    i1.req_valid = 1'b0;
    checks++; if ({i1.resp_valid, i1.resp_err, i1.resp_data} !== {2'b11, 16'h0000}) begin
      errors++; $display("FAIL err_load24: got %h want 3_0000", {i1.resp_valid, i1.resp_err, i1.resp_data}); end
    tick();
    i1.req_valid = 1'b1; i1.req_write = 1'b1; i1.req_addr = 16'hFFFF; i1.req_wdata = 16'hAAAA;
    tick();
    i1.req_valid = 1'b0;
    checks++; if ({i1.resp_valid, i1.resp_err, i1.resp_data} !== {2'b11, 16'h0000}) begin
      errors++; $display("FAIL err_storeFFFF: got %h want 3_0000", {i1.resp_valid, i1.resp_err, i1.resp_data}); end
    tick();
    checks++; if ((wr_cnt1 - w0) + (rd_cnt1 - r0) !== 0) begin
      errors++; $display("FAIL err_no_strobe: got %0d pulses want 0", (wr_cnt1 - w0) + (rd_cnt1 - r0)); end
  endtask

  task automatic test_backpressure();
    int w0 = wr_cnt1;
    i1.req_valid = 1'b1; i1.req_write = 1'b0; i1.req_addr = 16'd5; i1.resp_ready = 1'b0;
    tick();
    i1.req_valid = 1'b0;
    tick();
    i1.req_valid = 1'b1; i1.req_write = 1'b1; i1.req_addr = 16'd7; i1.req_wdata = 16'h5555;
    for (int c = 0; c < 3; c++) begin
      tick();
      checks++; if ({i1.resp_valid, i1.resp_err, i1.req_ready, i1.mem_write, i1.resp_data} !== {4'b1000, 16'h1234}) begin
        errors++; $display("FAIL bp_hold_%0d: got %h want 8_1234", c, {i1.resp_valid, i1.resp_err, i1.req_ready, i1.mem_write, i1.resp_data}); end
    end
    i1.req_valid = 1'b0; i1.resp_ready = 1'b1;
    tick();
    checks++; if ({i1.resp_valid, i1.req_ready} !== 2'b01) begin
      errors++; $display("FAIL bp_release: got %b want 01", {i1.resp_valid, i1.req_ready}); end
    checks++; if (mem1[7] !== 16'h0000 || wr_cnt1 != w0) begin
      errors++; $display("FAIL bp_ignored_req: got mem7=%h writes=%0d want 0000/0", mem1[7], wr_cnt1 - w0); end
  endtask

  task automatic test_reset_mid_read();
    i3.req_valid = 1'b1; i3.req_write = 1'b0; i3.req_addr = 16'd5; i3.resp_ready = 1'b1;
    tick();
    i3.req_valid = 1'b0;
    tick();
    checks++; if (i3.mem_read !== 1'b1) begin errors++; $display("FAIL rmid_read2: got %b want 1", i3.mem_read); end
    reset = 1'b1;
    #1;
    checks++; if ({i3.mem_read, i3.resp_valid, i3.req_ready} !== 3'b000) begin
      errors++; $display("FAIL rmid_async_drop: got %b want 000", {i3.mem_read, i3.resp_valid, i3.req_ready}); end
    tick();
    tick();
    reset = 1'b0;
    tick();
    checks++; if ({i3.req_ready, i3.resp_valid, i3.mem_read} !== 3'b100) begin
      errors++; $display("FAIL rmid_after_release: got %b want 100", {i3.req_ready, i3.resp_valid, i3.mem_read}); end
    tick();
    checks++; if (i3.resp_valid !== 1'b0) begin errors++; $display("FAIL rmid_no_resp: got %b want 0", i3.resp_valid); end
  endtask

  task automatic test_back_to_back();
    int a0 = acc_cnt1;
    i1.resp_ready = 1'b1;
    i1.req_valid = 1'b1; i1.req_write = 1'b1; i1.req_addr = 16'd23; i1.req_wdata = 16'hBEEF;
    tick();
    i1.req_write = 1'b0; i1.req_wdata = 16'h0000;
    checks++; if (i1.req_ready !== 1'b0) begin errors++; $display("FAIL b2b_busy_c1: got %b want 0", i1.req_ready); end
    tick();
    checks++; if ({i1.req_ready, i1.resp_valid} !== 2'b01) begin
      errors++; $display("FAIL b2b_busy_c2: got %b want 01", {i1.req_ready, i1.resp_valid}); end
    tick();
    checks++; if (i1.req_ready !== 1'b1) begin errors++; $display("FAIL b2b_idle_c3: got %b want 1", i1.req_ready); end
    tick();
    i1.req_valid = 1'b0;
    tick();
    checks++; if ({i1.resp_valid, i1.resp_err, i1.resp_data} !== {2'b10, 16'hBEEF}) begin
      errors++; $display("FAIL b2b_load_data: got %h want 2_beef", {i1.resp_valid, i1.resp_err, i1.resp_data}); end
    checks++; if (acc_cnt1 - a0 !== 2) begin errors++; $display("FAIL b2b_accepts: got %0d want 2", acc_cnt1 - a0); end
    tick();
  endtask

  initial begin
    checks = 0; errors = 0;
    wr_cnt1 = 0; rd_cnt1 = 0; rd_cnt3 = 0; acc_cnt1 = 0; both_seen = 1'b0;
    reset = 1'b1;
    i1.req_valid = 1'b0; i1.req_write = 1'b0; i1.req_addr = '0; i1.req_wdata = '0; i1.resp_ready = 1'b1;
    i3.req_valid = 1'b0; i3.req_write = 1'b0; i3.req_addr = '0; i3.req_wdata = '0; i3.resp_ready = 1'b1;
    test_reset();
    test_store();
    test_load_rw1();
    test_load_rw3();
    test_range_err();
    test_backpressure();
    test_reset_mid_read();
    test_back_to_back();
    checks++; if (both_seen !== 1'b0) begin errors++; $display("FAIL read_write_exclusive: got both=1 want 0"); end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #20000;
    $display("FAIL timeout: simulation did not complete within 20000 time units");
    $fatal(1, "timeout");
  end
endmodule
